// File: rtl/afifo_rd_stream.sv
`default_nettype none
// ============================================================================
// Module   : afifo_rd_stream
// Brief    : Async-FIFO read-side skid stage: pops the show-ahead port into a
//            2-entry register buffer and presents a valid/ready stream.
// Revision : 1.0 - initial release
// ============================================================================
module afifo_rd_stream #(
    parameter int DSIZE = 24,
    parameter int CNTW  = 16
) (
    input  logic             rclk,
    input  logic             rrst_n,
    input  logic             rempty,
    input  logic [DSIZE-1:0] rdata,
    output logic             rinc,
    output logic [DSIZE-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready,
    input  logic             flush,
    output logic [1:0]       level,
    output logic [CNTW-1:0]  xfer_cnt
);

    localparam logic [1:0] c_LVL_EMPTY = 2'd0;
    localparam logic [1:0] c_LVL_ONE   = 2'd1;
    localparam logic [1:0] c_LVL_FULL  = 2'd2;

    logic [1:0]       r_level;
    logic             r_valid;
    logic [DSIZE-1:0] r_head;
    logic [DSIZE-1:0] r_tail;
    logic [CNTW-1:0]  r_xfer_cnt;

    logic             w_pop;
    logic             w_xfer;
    logic [1:0]       w_level_nxt;
    logic             w_load_head;
    logic             w_head_from_tail;
    logic             w_load_tail;

    // Pop decision uses only registered occupancy, never m_ready, so the
    // FIFO read-pointer path stays short.
    assign w_pop  = rrst_n & ~rempty & ~flush & (r_level != c_LVL_FULL);
    assign w_xfer = r_valid & m_ready;

    always_comb begin
        w_level_nxt      = r_level;
        w_load_head      = 1'b0;
        w_head_from_tail = 1'b0;
        w_load_tail      = 1'b0;
        if (flush) begin
            w_level_nxt = c_LVL_EMPTY;
        end else begin
            case (r_level)
                c_LVL_EMPTY: begin
                    if (w_pop) begin
                        w_load_head = 1'b1;
                        w_level_nxt = c_LVL_ONE;
                    end
                end
                c_LVL_ONE: begin
                    case ({w_pop, w_xfer})
                        2'b11: w_load_head = 1'b1;
                        2'b10: begin
                            w_load_tail = 1'b1;
                            w_level_nxt = c_LVL_FULL;
                        end
                        2'b01: w_level_nxt = c_LVL_EMPTY;
                        default: w_level_nxt = r_level;
                    endcase
                end
                c_LVL_FULL: begin
                    if (w_xfer) begin
                        w_load_head      = 1'b1;
                        w_head_from_tail = 1'b1;
                        w_level_nxt      = c_LVL_ONE;
                    end
                end
                default: w_level_nxt = c_LVL_EMPTY;
            endcase
        end
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            r_level    <= c_LVL_EMPTY;
            r_valid    <= 1'b0;
            r_head     <= '0;
            r_xfer_cnt <= '0;
        end else begin
            r_level <= w_level_nxt;
            r_valid <= (w_level_nxt != c_LVL_EMPTY);
            if (w_load_head) begin
                r_head <= w_head_from_tail ? r_tail : rdata;
            end
            // A transfer on a flush edge still completed, so it is counted.
            if (w_xfer) begin
                r_xfer_cnt <= r_xfer_cnt + CNTW'(1);
            end
        end
    end

    // Tail is only observed after being written, so it carries no reset.
    always_ff @(posedge rclk) begin
        if (w_load_tail) begin
            r_tail <= rdata;
        end
    end

    assign rinc     = w_pop;
    assign m_data   = r_head;
    assign m_valid  = r_valid;
    assign level    = r_level;
    assign xfer_cnt = r_xfer_cnt;

endmodule
`default_nettype wire

// File: tb/tb_afifo_rd_stream.sv
`default_nettype none
// ============================================================================
// Module   : tb_afifo_rd_stream
// Brief    : Directed + random self-checking bench with a FIFO and stream model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_afifo_rd_stream;

    localparam int c_DSIZE = 24;

    logic               rclk;
    logic               rrst_n;
    logic               rempty;
    logic [c_DSIZE-1:0] rdata;
    logic               m_ready;
    logic               flush;

    logic               rinc,    rinc4;
    logic [c_DSIZE-1:0] m_data,  m_data4;
    logic               m_valid, m_valid4;
    logic [1:0]         level,   level4;
    logic [15:0]        xfer_cnt;
    logic [3:0]         xfer_cnt4;

    afifo_rd_stream #(.DSIZE(c_DSIZE), .CNTW(16)) dut (
        .rclk(rclk), .rrst_n(rrst_n), .rempty(rempty), .rdata(rdata),
        .rinc(rinc), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .flush(flush), .level(level), .xfer_cnt(xfer_cnt)
    );

    afifo_rd_stream #(.DSIZE(c_DSIZE), .CNTW(4)) dut4 (
        .rclk(rclk), .rrst_n(rrst_n), .rempty(rempty), .rdata(rdata),
        .rinc(rinc4), .m_data(m_data4), .m_valid(m_valid4), .m_ready(m_ready),
        .flush(flush), .level(level4), .xfer_cnt(xfer_cnt4)
    );

    initial rclk = 1'b0;
    always #5 rclk = ~rclk;

    int                 n_checks = 0;
    int                 n_fail   = 0;
    logic [c_DSIZE-1:0] fq[$];     // words sitting in the upstream FIFO
    logic [c_DSIZE-1:0] mq[$];     // words held by the stage, head first
    int unsigned        cnt;
    logic               hide;      // forces rempty high while FIFO has words

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic drive();
        rempty = hide || (fq.size() == 0);
        rdata  = (fq.size() != 0) ? fq[0] : '0;
    endtask

    // One rclk: check outputs against the model, clock, then advance the model.
    task automatic cycle();
        logic exp_rinc, exp_xfer;
        drive();
        #1;
        exp_rinc = rrst_n && !rempty && !flush && (mq.size() < 2);
        exp_xfer = (mq.size() != 0) && m_ready;
        check_eq("rinc",     32'(rinc),      32'(exp_rinc));
        check_eq("m_valid",  32'(m_valid),   32'(mq.size() != 0));
        check_eq("level",    32'(level),     mq.size());
        if (mq.size() != 0) check_eq("m_data", 32'(m_data), 32'(mq[0]));
        check_eq("xfer_cnt", 32'(xfer_cnt),  cnt & 32'hFFFF);
        check_eq("xfer_cnt4", 32'(xfer_cnt4), cnt & 32'hF);
        @(posedge rclk);
        #1;
        if (exp_xfer) begin
            void'(mq.pop_front());
            cnt++;
        end
        if (flush) mq.delete();
        else if (exp_rinc) mq.push_back(fq.pop_front());
    endtask

    task automatic do_reset();
        rrst_n  = 1'b0;
        m_ready = 1'b0;
        flush   = 1'b0;
        hide    = 1'b0;
        mq.delete();
        cnt = 0;
        drive();
        #1;
        check_eq("rst_rinc",  32'(rinc),     0);
        check_eq("rst_valid", 32'(m_valid),  0);
        check_eq("rst_data",  32'(m_data),   0);
        check_eq("rst_cnt",   32'(xfer_cnt), 0);
        check_eq("rst_level", 32'(level),    0);
        @(negedge rclk);
        rrst_n = 1'b1;
    endtask

    initial begin
        logic [c_DSIZE-1:0] held;
        rrst_n = 1'b1; m_ready = 1'b0; flush = 1'b0; hide = 1'b0;
        rempty = 1'b1; rdata = '0; cnt = 0;

        // Reset with a non-empty FIFO, then first-word latency.
        fq.delete();
        for (int i = 1; i <= 3; i++) fq.push_back(24'hA00000 + c_DSIZE'(i));
        @(negedge rclk);
        do_reset();
        drive(); #1;
        check_eq("first_rinc", 32'(rinc), 1);
        cycle();
        drive(); #1;
        check_eq("first_valid", 32'(m_valid), 1);
        check_eq("first_data",  32'(m_data),  32'h00A00001);

        // Streaming 0x000001..0x000010 with m_ready held high.
        fq.delete();
        for (int i = 1; i <= 16; i++) fq.push_back(c_DSIZE'(i));
        do_reset();
        m_ready = 1'b1;
        for (int i = 0; i < 20; i++) cycle();
        check_eq("stream_cnt",   32'(xfer_cnt), 16);
        check_eq("stream_valid", 32'(m_valid),  0);

        // Back-pressure: two pops then hold, then a one-cycle accept.
        fq.delete();
        for (int i = 1; i <= 6; i++) fq.push_back(24'hB00000 + c_DSIZE'(i));
        do_reset();
        for (int i = 0; i < 5; i++) cycle();
        check_eq("bp_level", 32'(level),  2);
        check_eq("bp_data",  32'(m_data), 32'h00B00001);
        check_eq("bp_fifo",  fq.size(),   4);
        m_ready = 1'b1;
        cycle();
        m_ready = 1'b0;
        drive(); #1;
        check_eq("bp_lvl1",  32'(level),  1);
        check_eq("bp_head",  32'(m_data), 32'h00B00002);
        check_eq("bp_rinc",  32'(rinc),   1);
        cycle();
        check_eq("bp_lvl2",  32'(level),  2);

        // Flush at level 2 with m_ready=1: transfer still counts.
        m_ready = 1'b1;
        flush   = 1'b1;
        held    = fq[0];
        cycle();
        flush   = 1'b0;
        m_ready = 1'b0;
        drive(); #1;
        check_eq("fl_cnt",   32'(xfer_cnt), 2);
        check_eq("fl_level", 32'(level),    0);
        check_eq("fl_valid", 32'(m_valid),  0);
        cycle();
        check_eq("fl_next",  32'(m_data),   32'(held));

        // Counter wrap on the 4-bit instance: 17 transfers -> 1.
        fq.delete();
        for (int i = 0; i < 17; i++) fq.push_back(24'hC00000 + c_DSIZE'(i));
        do_reset();
        m_ready = 1'b1;
        for (int i = 0; i < 20; i++) cycle();
        check_eq("wrap_cnt4", 32'(xfer_cnt4), 1);
        check_eq("wrap_cnt",  32'(xfer_cnt),  17);

        // Random rempty / m_ready with occasional flush.
        fq.delete();
        do_reset();
        for (int i = 0; i < 10000; i++) begin
            if (fq.size() < 4) fq.push_back(c_DSIZE'($urandom));
            hide    = ($urandom_range(0, 3) == 0);
            m_ready = ($urandom_range(0, 2) != 0);
            flush   = ($urandom_range(0, 99) == 0);
            cycle();
            check_eq("lvl_max", 32'(level <= 2'd2), 1);
        end
        flush = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
